// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
//   Instruction fetch initiator. Drives word addresses into a fixed-latency,
//   handshake-free instruction BRAM, tracks outstanding reads in a shift pipe,
//   captures returning words with their PC into a small FIFO and hands them to
//   decode over a valid/ready handshake. A redirect flushes everything in
//   flight and everything buffered, then restarts fetching at the target.
//
// Ports
//   clk            core clock
//   rst_n          asynchronous active-low reset
//   imem_addr      byte address to instruction memory (word aligned)
//   imem_q         memory read data, MEM_LATENCY cycles after the address
//   redirect_valid branch/jump taken this cycle
//   redirect_pc    redirect target (bits [1:0] ignored)
//   inst_valid     buffer holds at least one instruction
//   inst           instruction at buffer head
//   inst_pc        PC of the instruction at buffer head
//   inst_ready     decode accepts the head this cycle
// -----------------------------------------------------------------------------
module imem_fetch_unit #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter int          MEM_LATENCY = 2,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_q,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        inst_ready
);

  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = $clog2(FIFO_DEPTH) + 1;
  localparam int IFW = $clog2(MEM_LATENCY + 1);

  // Fetch PC and read-tracking pipe
  logic [31:0]            r_pc;
  logic [MEM_LATENCY-1:0] r_pipe_vld;
  logic [31:0]            r_pipe_pc [MEM_LATENCY];

  // Instruction buffer
  logic [31:0]   r_mem_inst [FIFO_DEPTH];
  logic [31:0]   r_mem_pc   [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  // Registered decode-side outputs
  logic          r_inst_valid;
  logic [31:0]   r_inst;
  logic [31:0]   r_inst_pc;

  logic [IFW-1:0] w_in_flight;
  logic           w_issue;
  logic           w_push;
  logic           w_pop;
  logic [31:0]    w_redirect_tgt;
  logic [31:0]    w_ret_pc;
  logic [PW-1:0]  w_wr_ptr_nxt;
  logic [PW-1:0]  w_rd_ptr_nxt;
  logic [CW-1:0]  w_count_nxt;
  logic [31:0]    w_head_inst_nxt;
  logic [31:0]    w_head_pc_nxt;

  assign imem_addr      = r_pc;
  assign inst_valid     = r_inst_valid;
  assign inst           = r_inst;
  assign inst_pc        = r_inst_pc;
  // Masking keeps the low target bits out of the PC without leaving them unread.
  assign w_redirect_tgt = redirect_pc & 32'hFFFF_FFFC;
  assign w_ret_pc       = r_pipe_pc[MEM_LATENCY-1];

  // Credit accounting: reads in flight plus buffered words may never exceed
  // the buffer depth, so every outstanding read is guaranteed a slot.
  always_comb begin
    w_in_flight = '0;
    for (int i = 0; i < MEM_LATENCY; i++) begin
      if (r_pipe_vld[i]) begin
        w_in_flight = w_in_flight + IFW'(1);
      end else begin
        w_in_flight = w_in_flight;
      end
    end
    w_issue = !redirect_valid &&
              ((32'(r_count) + 32'(w_in_flight)) < 32'(FIFO_DEPTH));
    // A redirect drops the arriving return and ignores any pop.
    w_push  = r_pipe_vld[MEM_LATENCY-1] && !redirect_valid;
    w_pop   = r_inst_valid && inst_ready && !redirect_valid;
  end

  // Buffer next-state: pointers, occupancy and the next head entry
  always_comb begin
    w_wr_ptr_nxt    = r_wr_ptr;
    w_rd_ptr_nxt    = r_rd_ptr;
    w_count_nxt     = r_count;
    w_head_inst_nxt = r_inst;
    w_head_pc_nxt   = r_inst_pc;
    if (redirect_valid) begin
      w_wr_ptr_nxt = '0;
      w_rd_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_push) begin
        w_wr_ptr_nxt = r_wr_ptr + PW'(1);
      end else begin
        w_wr_ptr_nxt = r_wr_ptr;
      end
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PW'(1);
      end else begin
        w_rd_ptr_nxt = r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   w_count_nxt = r_count + CW'(1);
        2'b01:   w_count_nxt = r_count - CW'(1);
        default: w_count_nxt = r_count;
      endcase
      // The new head may be the word being written this very cycle, in which
      // case it is taken straight from the return path.
      if (w_count_nxt != '0) begin
        if (w_push && (r_wr_ptr == w_rd_ptr_nxt)) begin
          w_head_inst_nxt = imem_q;
          w_head_pc_nxt   = w_ret_pc;
        end else begin
          w_head_inst_nxt = r_mem_inst[w_rd_ptr_nxt];
          w_head_pc_nxt   = r_mem_pc[w_rd_ptr_nxt];
        end
      end else begin
        w_head_inst_nxt = r_inst;
        w_head_pc_nxt   = r_inst_pc;
      end
    end
  end

  // Fetch PC and the read-tracking shift pipe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc       <= RESET_PC;
      r_pipe_vld <= '0;
      for (int i = 0; i < MEM_LATENCY; i++) begin
        r_pipe_pc[i] <= 32'h0000_0000;
      end
    end else begin
      if (redirect_valid) begin
        r_pc <= w_redirect_tgt;
      end else if (w_issue) begin
        r_pc <= r_pc + 32'd4;
      end
      r_pipe_vld[0] <= w_issue;
      r_pipe_pc[0]  <= r_pc;
      for (int i = 1; i < MEM_LATENCY; i++) begin
        r_pipe_vld[i] <= r_pipe_vld[i-1] && !redirect_valid;
        r_pipe_pc[i]  <= r_pipe_pc[i-1];
      end
    end
  end

  // Buffer storage; cleared on reset so the head is never unknown
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem_inst[i] <= 32'h0000_0000;
        r_mem_pc[i]   <= 32'h0000_0000;
      end
    end else if (w_push) begin
      r_mem_inst[r_wr_ptr] <= imem_q;
      r_mem_pc[r_wr_ptr]   <= w_ret_pc;
    end
  end

  // Buffer pointers, occupancy and registered head outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      r_count      <= '0;
      r_inst_valid <= 1'b0;
      r_inst       <= 32'h0000_0000;
      r_inst_pc    <= 32'h0000_0000;
    end else begin
      r_wr_ptr     <= w_wr_ptr_nxt;
      r_rd_ptr     <= w_rd_ptr_nxt;
      r_count      <= w_count_nxt;
      r_inst_valid <= (w_count_nxt != '0);
      r_inst       <= w_head_inst_nxt;
      r_inst_pc    <= w_head_pc_nxt;
    end
  end

  imem_fetch_unit_chk #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_chk (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .pop       (w_pop),
    .count     (32'(r_count)),
    .addr_lsb  (r_pc[1:0])
  );

endmodule

// -----------------------------------------------------------------------------
// imem_fetch_unit_chk
//   Protocol checks for the fetch unit: the buffer never overflows and the
//   fetch address is always word aligned.
//
// Ports
//   clk, rst_n  clock and asynchronous active-low reset
//   push, pop   buffer write / read this cycle
//   count       buffer occupancy
//   addr_lsb    low two bits of the fetch address
// -----------------------------------------------------------------------------
module imem_fetch_unit_chk #(
  parameter int FIFO_DEPTH = 4
) (
  input logic        clk,
  input logic        rst_n,
  input logic        push,
  input logic        pop,
  input logic [31:0] count,
  input logic [1:0]  addr_lsb
);

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop && (count >= 32'(FIFO_DEPTH))))
    else $error("instruction buffer overflow");

  a_addr_aligned: assert property (@(posedge clk) disable iff (!rst_n)
    addr_lsb == 2'b00)
    else $error("fetch address not word aligned");

endmodule

// File: tb/tb_imem_fetch_unit.sv
module tb_imem_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_q;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_ready;

  // Second instance starting near the top of the address space
  logic [31:0] w_addr;
  logic [31:0] w_q;
  logic        w_valid;
  logic [31:0] w_inst;
  logic [31:0] w_inst_pc;

  always #5 clk = ~clk;

  imem_fetch_unit #(.RESET_PC(32'h0000_0000), .MEM_LATENCY(2), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_q(imem_q),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc), .inst_ready(inst_ready));

  imem_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .MEM_LATENCY(2), .FIFO_DEPTH(4)) u_wrap (
    .clk(clk), .rst_n(rst_n), .imem_addr(w_addr), .imem_q(w_q),
    .redirect_valid(1'b0), .redirect_pc(32'h0000_0000),
    .inst_valid(w_valid), .inst(w_inst), .inst_pc(w_inst_pc), .inst_ready(1'b1));

  function automatic logic [31:0] rom(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2);
  endfunction

  // Two-cycle ROM: word for the address driven in cycle t appears in cycle t+2
  logic [31:0] q1, q2, wq1, wq2;
  always @(posedge clk) begin
    q1  <= rom(imem_addr);
    q2  <= q1;
    wq1 <= rom(w_addr);
    wq2 <= wq1;
  end
  assign imem_q = q2;
  assign w_q    = wq2;

  int          n_checks = 0;
  int          n_pass   = 0;
  int          n_deliv  = 0;
  int          base;
  logic [31:0] exp_q [$];
  logic [31:0] mon_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", name, act, exp);
  endtask

  // Reference model: after a reset or redirect the delivered stream is the
  // aligned start address followed by consecutive words.
  task automatic restart_model(input logic [31:0] start);
    exp_q.delete();
    exp_q.push_back(start & 32'hFFFF_FFFC);
  endtask

  // Monitor: every accepted handshake pops the next expected PC
  always @(negedge clk) begin
    if (rst_n && inst_valid && inst_ready && !redirect_valid) begin
      mon_pc = exp_q.pop_front();
      chk("deliv_pc", inst_pc, mon_pc);
      chk("deliv_inst", inst, rom(mon_pc));
      n_deliv++;
      if (exp_q.size() == 0) exp_q.push_back(mon_pc + 32'd4);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset(input logic rdy);
    rst_n          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    inst_ready     = rdy;
    restart_model(32'h0000_0000);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // Called in cycle 0 after reset release with inst_ready=1
  task automatic check_startup();
    chk("rst_valid", 32'(inst_valid), 32'd0);
    chk("rst_addr", imem_addr, 32'h0000_0000);
    chk("rst_inst", inst, 32'h0000_0000);
    chk("rst_pc", inst_pc, 32'h0000_0000);
    chk("wrap_rst_addr", w_addr, 32'hFFFF_FFF8);
    cyc(1);
    chk("addr_c1", imem_addr, 32'h0000_0004);
    cyc(1);
    chk("valid_c2", 32'(inst_valid), 32'd0);
    cyc(1);
    chk("valid_c3", 32'(inst_valid), 32'd1);
    chk("pc_c3", inst_pc, 32'h0000_0000);
    chk("inst_c3", inst, 32'h1000_0000);
    for (int k = 0; k < 4; k++) begin
      chk("wrap_valid", 32'(w_valid), 32'd1);
      chk("wrap_pc", w_inst_pc, 32'hFFFF_FFF8 + 32'(4 * k));
      chk("wrap_inst", w_inst, rom(32'hFFFF_FFF8 + 32'(4 * k)));
      cyc(1);
    end
    base = n_deliv;
    cyc(10);
    chk("stream_rate", 32'(n_deliv - base), 32'd10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n          = 1'b0;
    inst_ready     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0000_0000;
    restart_model(32'h0000_0000);

    // Streaming after reset
    do_reset(1'b1);
    check_startup();

    // Backpressure from the start: buffer fills, address sticks at 0x10
    do_reset(1'b0);
    cyc(10);
    chk("stall_addr", imem_addr, 32'h0000_0010);
    chk("stall_valid", 32'(inst_valid), 32'd1);
    chk("stall_head", inst_pc, 32'h0000_0000);
    cyc(5);
    chk("stall_addr_hold", imem_addr, 32'h0000_0010);
    chk("stall_head_hold", inst_pc, 32'h0000_0000);
    inst_ready = 1'b1;
    base = n_deliv;
    cyc(10);
    chk("resume_rate", 32'(n_deliv - base), 32'd10);

    // Asynchronous reset with the buffer full
    inst_ready = 1'b0;
    cyc(10);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_valid", 32'(inst_valid), 32'd0);
    chk("async_addr", imem_addr, 32'h0000_0000);
    restart_model(32'h0000_0000);
    inst_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_startup();

    // Redirect with 2 buffered and 2 in flight
    do_reset(1'b0);
    cyc(4);
    chk("pre_redir_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    restart_model(32'h0000_0043);
    cyc(1);
    redirect_valid = 1'b0;
    chk("redir_valid", 32'(inst_valid), 32'd0);
    chk("redir_addr", imem_addr, 32'h0000_0040);
    inst_ready = 1'b1;
    base = n_deliv;
    cyc(8);
    chk("redir_rate", 32'(n_deliv - base), 32'd5);

    // Redirect with a simultaneous pop and arriving return
    chk("pre_redir2_valid", 32'(inst_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h1234_567B;
    restart_model(32'h1234_567B);
    cyc(1);
    redirect_valid = 1'b0;
    chk("redir2_valid", 32'(inst_valid), 32'd0);
    chk("redir2_addr", imem_addr, 32'h1234_5678);
    base = n_deliv;
    cyc(6);
    chk("redir2_rate", 32'(n_deliv - base), 32'd3);

    // Back-to-back redirects: only the last target is fetched
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    restart_model(32'h0000_0100);
    cyc(1);
    redirect_pc    = 32'h0000_0200;
    restart_model(32'h0000_0200);
    cyc(1);
    redirect_valid = 1'b0;
    chk("b2b_addr", imem_addr, 32'h0000_0200);
    cyc(8);

    // Randomized backpressure and redirects
    base = n_deliv;
    for (int c = 0; c < 1500; c++) begin
      inst_ready = ($urandom_range(0, 99) < 70);
      if ($urandom_range(0, 99) < 3) begin
        redirect_valid = 1'b1;
        redirect_pc    = $urandom;
        restart_model(redirect_pc);
      end else begin
        redirect_valid = 1'b0;
      end
      cyc(1);
    end
    redirect_valid = 1'b0;
    inst_ready     = 1'b1;
    cyc(10);
    chk("rand_deliv", 32'(n_deliv - base >= 500), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
